// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-source round-robin mux arbiter:
// source indices, FSM state encoding and a one-hot helper.
package mux4_rr_arbiter_pkg;

    localparam int N_SRC = 4;

    localparam logic [1:0] SRC_A = 2'd0;
    localparam logic [1:0] SRC_B = 2'd1;
    localparam logic [1:0] SRC_C = 2'd2;
    localparam logic [1:0] SRC_D = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    function automatic logic [N_SRC-1:0] onehot4(input logic [1:0] idx);
        logic [N_SRC-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first requester scanning ptr+1, ptr+2,
// ptr+3, ptr (mod 4). valid is low when nothing is requesting.
module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [1:0]       ptr,
    output logic [1:0]       idx,
    output logic             valid
);

    logic [1:0]       cand [N_SRC];
    logic [N_SRC-1:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_cand
            // Scan position gi holds source ptr+gi+1; the last position wraps back to ptr itself.
            assign cand[gi] = ptr + 2'(gi + 1);
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        idx   = ptr;
        valid = 1'b0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx   = cand[k];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that grants one of four sources a bounded slot on the
// shared 4:1 mux and drives the mux select/enable directly.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] req,
    input  logic             arb_en,
    output logic [1:0]       sel,
    output logic             en,
    output logic [N_SRC-1:0] gnt,
    output logic             slot_end
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       sel_q, sel_d;
    logic [N_SRC-1:0] gnt_q, gnt_d;

    logic [1:0] pick_ptr;
    logic [1:0] pick_idx;
    logic       pick_valid;
    logic       last_cnt;
    logic       slot_done;

    // At a slot end the holder is the newest "last granted", so scan from it directly.
    assign pick_ptr = (state_q == ST_GRANT) ? sel_q : ptr_q;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign last_cnt  = (cnt_q == CNT_W'(HOLD_CYCLES - 1));
    assign slot_done = (state_q == ST_GRANT) && (last_cnt || !req[sel_q] || !arb_en);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_en && pick_valid) begin
                    state_d = ST_GRANT;
                    sel_d   = pick_idx;
                    gnt_d   = onehot4(pick_idx);
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                if (slot_done) begin
                    ptr_d = sel_q;
                    cnt_d = '0;
                    if (arb_en && pick_valid) begin
                        sel_d = pick_idx;
                        gnt_d = onehot4(pick_idx);
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= SRC_D;
            sel_q   <= SRC_A;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
        end
    end

    assign sel = sel_q;
    assign en  = (state_q == ST_GRANT);
    assign gnt = gnt_q;
    // Early release and arb_en drop are only known in the final cycle itself, so the
    // pulse is decoded from registered slot state plus the live end conditions.
    assign slot_end = slot_done && !rst;

endmodule
